// File: rtl/sp_ram_pkg.sv
// Shared types and elaboration helpers for the byte-enable pipelined single-port RAM.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int MAX_OUT_REGS = 4;

  function automatic int rd_latency(input int out_regs);
    return 2 + out_regs;
  endfunction

  function automatic bit cfg_ok(input int dw, input int byte_w, input int out_regs);
    return (byte_w > 0) && ((dw % byte_w) == 0) && (out_regs >= 0) && (out_regs <= MAX_OUT_REGS);
  endfunction

endpackage

// File: rtl/sp_ram_init_fsm.sv
// Init/clear sequencer: sweeps every address once after reset or clr, owns rdy.
// One init write per cycle; requesters are held off (rdy=0) for 1 DRAIN + DEPTH INIT cycles.
module sp_ram_init_fsm
  import sp_ram_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          rdy_o,
  output logic          init_we_o,
  output logic [AW-1:0] init_addr_o
);

  // One extra bit so the counter parks at DEPTH instead of wrapping to 0.
  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  state_e      state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (clr_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy_o       = (state_q == ST_READY);
  assign init_we_o   = (state_q == ST_INIT);
  assign init_addr_o = cnt_q[AW-1:0];

endmodule

// File: rtl/sp_ram_be_pipe.sv
// Single-port RAM, per-byte write enables, read latency 2+OUT_REGS, one request per cycle.
// No backpressure once rdy=1; requests are refused while the init engine owns the array.
module sp_ram_be_pipe
  import sp_ram_pkg::*;
#(
  parameter int              AW            = 10,
  parameter int              DW            = 64,
  parameter int              BYTE_W        = 8,
  parameter int              OUT_REGS      = 1,
  parameter logic [DW-1:0]   INIT_VAL      = '0,
  parameter string           RAM_STYLE_VAL = "block"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  output logic                 rdy_o,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [DW/BYTE_W-1:0] be_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        din_i,
  output logic                 rd_valid_o,
  output logic [DW-1:0]        dout_o
);

  localparam int NB     = DW / BYTE_W;
  localparam int DEPTH  = 2 ** AW;
  localparam int LAT    = rd_latency(OUT_REGS);
  localparam bit CFG_OK = cfg_ok(DW, BYTE_W, OUT_REGS);

  generate
    if (!CFG_OK || (RAM_STYLE_VAL == "")) begin : g_cfg_err
      $error("sp_ram_be_pipe: DW must be a multiple of BYTE_W, OUT_REGS in 0..4, RAM_STYLE_VAL non-empty");
    end
  endgenerate

  logic          init_we;
  logic [AW-1:0] init_addr;

  sp_ram_init_fsm #(.AW(AW)) u_init (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_i),
    .rdy_o       (rdy_o),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  logic          acc;
  logic          s1_vld_q, s1_we_q;
  logic [NB-1:0] s1_be_q;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_din_q;

  assign acc = req_i & rdy_o & ~clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_we_q   <= 1'b0;
      s1_be_q   <= '0;
      s1_addr_q <= '0;
      s1_din_q  <= '0;
    end else begin
      s1_vld_q <= acc;
      if (acc) begin
        s1_we_q   <= we_i;
        s1_be_q   <= be_i;
        s1_addr_q <= addr_i;
        s1_din_q  <= din_i;
      end
    end
  end

  // Init port wins the array; DRAIN guarantees no user access is pending then.
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] wr_dat;

  assign wr_en   = init_we | (s1_vld_q & s1_we_q);
  assign rd_en   = s1_vld_q & ~s1_we_q & ~init_we;
  assign wr_addr = init_we ? init_addr : s1_addr_q;
  assign wr_be   = init_we ? {NB{1'b1}} : s1_be_q;
  assign wr_dat  = init_we ? INIT_VAL : s1_din_q;

  (* ram_style = RAM_STYLE_VAL *) logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] ram_dat_q;
  logic          ram_vld_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_dat[i*BYTE_W +: BYTE_W];
      end
    end
    if (rd_en) ram_dat_q <= mem_q[s1_addr_q];
  end

  // Stage 0 is the read register, stages 1..OUT_REGS are retiming stages.
  logic [LAT-2:0] pipe_vld_q;
  logic [DW-1:0]  pipe_dat_q [LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld_q  <= 1'b0;
      pipe_vld_q <= '0;
      for (int i = 0; i < LAT-1; i++) pipe_dat_q[i] <= '0;
    end else begin
      ram_vld_q     <= rd_en;
      pipe_vld_q[0] <= ram_vld_q;
      if (ram_vld_q) pipe_dat_q[0] <= ram_dat_q;
      for (int i = 1; i < LAT-1; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  assign rd_valid_o = pipe_vld_q[LAT-2];
  assign dout_o     = pipe_dat_q[LAT-2];

endmodule

// File: tb/tb_sp_ram_be_pipe.sv
// Directed bench: three instances (OUT_REGS 1, 0, 3) share one stimulus stream.
module tb_sp_ram_be_pipe;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        req;
  logic        we;
  logic [7:0]  be;
  logic [9:0]  addr;
  logic [63:0] din;

  logic        rdy1, rv1, rdy0, rv0, rdy3, rv3;
  logic [63:0] do1, do0, do3;

  int n_chk  = 0;
  int n_fail = 0;

  // index 0: OUT_REGS=1, 1: OUT_REGS=0, 2: OUT_REGS=3
  int          lat_tab [3] = '{3, 2, 5};
  logic [2:0]  rv_all;
  logic [63:0] do_all [3];
  assign rv_all    = {rv3, rv0, rv1};
  assign do_all[0] = do1;
  assign do_all[1] = do0;
  assign do_all[2] = do3;

  sp_ram_be_pipe #(.OUT_REGS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .rdy_o(rdy1), .req_i(req), .we_i(we),
    .be_i(be), .addr_i(addr), .din_i(din), .rd_valid_o(rv1), .dout_o(do1)
  );
  sp_ram_be_pipe #(.OUT_REGS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .rdy_o(rdy0), .req_i(req), .we_i(we),
    .be_i(be), .addr_i(addr), .din_i(din), .rd_valid_o(rv0), .dout_o(do0)
  );
  sp_ram_be_pipe #(.OUT_REGS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .rdy_o(rdy3), .req_i(req), .we_i(we),
    .be_i(be), .addr_i(addr), .din_i(din), .rd_valid_o(rv3), .dout_o(do3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] b, input logic [9:0] a, input logic [63:0] d);
    req = 1'b1; we = w; be = b; addr = a; din = d;
    cyc();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; clr = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
    #22;
    n_chk++;
    if (rdy1 !== 1'b0 || rv1 !== 1'b0 || do1 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b rd_valid=%b dout=%h, required 0 0 0", rdy1, rv1, do1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (rdy1 !== 1'b1 && n < 3000) begin
      cyc();
      n++;
    end
    n_chk++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL reset_init_len: rdy low for %0d cycles, required %0d", n, DEPTH);
    end
    n_chk++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy_all: rdy0=%b rdy3=%b, required 1 1", rdy0, rdy3);
    end
  endtask

  task automatic test_init_reads();
    logic [9:0] a_tab [3] = '{10'd0, 10'd512, 10'd1023};
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 8'h00, a_tab[j], 64'h0);
      for (int k = 1; k <= 3; k++) begin
        cyc();
        n_chk++;
        if (k < 3 && rv1 !== 1'b0) begin
          n_fail++;
          $display("FAIL init_read_early addr=%0d k=%0d: rd_valid=%b, required 0", a_tab[j], k, rv1);
        end else if (k == 3 && (rv1 !== 1'b1 || do1 !== 64'h0)) begin
          n_fail++;
          $display("FAIL init_read addr=%0d: rd_valid=%b dout=%h, required 1 0", a_tab[j], rv1, do1);
        end
      end
    end
  endtask

  task automatic test_byte_en();
    drive(1'b1, 8'hFF, 10'd5, 64'h1111_2222_3333_4444);
    drive(1'b1, 8'h0F, 10'd5, 64'hAAAA_AAAA_AAAA_AAAA);
    drive(1'b1, 8'h00, 10'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rv1 !== 1'b0 || do1 !== 64'h0) begin
        n_fail++;
        $display("FAIL write_no_read k=%0d: rd_valid=%b dout=%h, required 0 0", k, rv1, do1);
      end
      cyc();
    end
    drive(1'b0, 8'h00, 10'd5, 64'h0);
    repeat (3) cyc();
    n_chk++;
    if (rv1 !== 1'b1 || do1 !== 64'h1111_2222_AAAA_AAAA) begin
      n_fail++;
      $display("FAIL byte_en: rd_valid=%b dout=%h, required 1 1111_2222_aaaa_aaaa", rv1, do1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(1'b1, 8'hFF, 10'(i), 64'(i));
    for (int s = 0; s < 24; s++) begin
      if (s < 16) begin
        req = 1'b1; we = 1'b0; addr = 10'(s);
      end else begin
        req = 1'b0;
      end
      cyc();
      for (int d = 0; d < 3; d++) begin
        logic exp_v;
        exp_v = (s >= lat_tab[d]) && (s < lat_tab[d] + 16);
        n_chk++;
        if (rv_all[d] !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_valid lat=%0d s=%0d: rd_valid=%b, required %b", lat_tab[d], s, rv_all[d], exp_v);
        end
        if (exp_v) begin
          n_chk++;
          if (do_all[d] !== 64'(s - lat_tab[d])) begin
            n_fail++;
            $display("FAIL b2b_data lat=%0d s=%0d: dout=%h, required %h", lat_tab[d], s, do_all[d], 64'(s - lat_tab[d]));
          end
        end else if (s >= lat_tab[d] + 16) begin
          n_chk++;
          if (do_all[d] !== 64'd15) begin
            n_fail++;
            $display("FAIL b2b_hold lat=%0d s=%0d: dout=%h, required f", lat_tab[d], s, do_all[d]);
          end
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_wr_rd();
    drive(1'b1, 8'hFF, 10'd7, 64'hDEAD_BEEF);
    drive(1'b0, 8'h00, 10'd7, 64'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      for (int d = 0; d < 3; d++) begin
        if (k == lat_tab[d]) begin
          n_chk++;
          if (rv_all[d] !== 1'b1 || do_all[d] !== 64'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_then_rd lat=%0d: rd_valid=%b dout=%h, required 1 deadbeef", lat_tab[d], rv_all[d], do_all[d]);
          end
        end
      end
    end
  endtask

  task automatic test_clear();
    int n;
    int pulses [3];
    pulses = '{0, 0, 0};
    drive(1'b1, 8'hFF, 10'd3, 64'h33);
    drive(1'b1, 8'hFF, 10'd9, 64'h99);
    cyc();
    drive(1'b0, 8'h00, 10'd3, 64'h0);
    clr = 1'b1; req = 1'b1; we = 1'b0; addr = 10'd9;
    cyc();
    clr = 1'b0; req = 1'b0;
    n = 0;
    while (rdy1 !== 1'b1 && n < 3000) begin
      for (int d = 0; d < 3; d++) begin
        if (rv_all[d] === 1'b1) begin
          pulses[d]++;
          n_chk++;
          if (do_all[d] !== 64'h33) begin
            n_fail++;
            $display("FAIL clr_inflight lat=%0d: dout=%h, required 33", lat_tab[d], do_all[d]);
          end
        end
      end
      n++;
      clr = (n == 1) || (n == 100);
      cyc();
    end
    clr = 1'b0;
    n_chk++;
    if (n !== DEPTH + 1) begin
      n_fail++;
      $display("FAIL clr_rdy_low: rdy low for %0d cycles, required %0d", n, DEPTH + 1);
    end
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (pulses[d] !== 1) begin
        n_fail++;
        $display("FAIL clr_pulses lat=%0d: %0d rd_valid pulses, required 1", lat_tab[d], pulses[d]);
      end
    end
    drive(1'b0, 8'h00, 10'd3, 64'h0);
    drive(1'b0, 8'h00, 10'd9, 64'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k >= 2) begin
        n_chk++;
        if (rv1 !== 1'b1 || do1 !== 64'h0) begin
          n_fail++;
          $display("FAIL clr_readback k=%0d: rd_valid=%b dout=%h, required 1 0", k, rv1, do1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    drive(1'b1, 8'hFF, 10'd1, 64'h5A5A);
    drive(1'b0, 8'h00, 10'd1, 64'h0);
    repeat (3) cyc();
    n_chk++;
    if (rv1 !== 1'b1 || do1 !== 64'h5A5A) begin
      n_fail++;
      $display("FAIL pre_reset_read: rd_valid=%b dout=%h, required 1 5a5a", rv1, do1);
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (100) cyc();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rv1 !== 1'b0 || do1 !== 64'h0 || do0 !== 64'h0 || do3 !== 64'h0 || rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_init_reset: rd_valid=%b dout=%h/%h/%h rdy=%b, required 0 0/0/0 0", rv1, do1, do0, do3, rdy1);
    end
    repeat (3) cyc();
    rst_n = 1'b1;
    n = 0;
    while (rdy1 !== 1'b1 && n < 3000) begin
      cyc();
      n++;
    end
    n_chk++;
    if (n !== DEPTH) begin
      n_fail++;
      $display("FAIL mid_init_restart: rdy low for %0d cycles, required %0d", n, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_byte_en();
    test_back_to_back();
    test_wr_rd();
    test_clear();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_be_pipe.md
Name: sp_ram_be_pipe

Overview:
Parametrised single-port synchronous RAM with registered request inputs, per-byte write enables, configurable output pipeline depth and a read-valid strobe. A built-in init engine clears the whole array after reset or on command, and signals readiness to the requester. It is the general-purpose on-chip buffer and table store for datapath blocks that need byte-granular writes and a timing-closable read path.

Parameters:
AW, 10, address width; DEPTH = 2**AW words
DW, 64, data width; must be a multiple of BYTE_W
BYTE_W, 8, bits per write-enable lane; NB = DW/BYTE_W
OUT_REGS, 1, extra output register stages after the RAM read register (0..4)
INIT_VAL, '0, DW-bit word written to every address by the init engine
RAM_STYLE_VAL, "block", synthesis RAM_STYLE attribute applied to the array

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  request a full re-initialisation; sampled only while rdy=1
rdy  output  1  1 = requests accepted; 0 during reset, drain and init
req  input  1  request valid; ignored when rdy=0 or clr=1
we  input  1  1 = write, 0 = read; qualified by req
be  input  NB  byte write enables; lane i covers din[i*BYTE_W +: BYTE_W]
addr  input  AW  word address
din  input  DW  write data
rd_valid  output  1  1-cycle strobe: dout holds read data
dout  output  DW  read data; holds the last read value between reads

Behaviour:
- Reset is asynchronous on rst_n low. Reset values: rdy=0, rd_valid=0, dout='0, all pipeline valids=0, FSM=INIT, init address=0. Array contents are not reset directly; they are cleared only by the init engine.
- Accepted request: req & rdy & ~clr at edge T. The request is registered at T. The array is accessed in the following cycle, and the read register is loaded at T+2.
- Read latency LAT = 2 + OUT_REGS. rd_valid is high for exactly one cycle following edge T+LAT, with dout = the word at addr.
- Fully pipelined: one request per cycle, with no bubbles.
- Write: only lanes with be[i]=1 are updated. A write with be=0 is a no-op. Writes never assert rd_valid and never change dout.
- Read after write to the same address, issued on the next cycle or later, returns the new data.
- dout and every output stage update only when their stage valid is set; otherwise they hold.
- FSM states:
  - INIT: writes INIT_VAL at the init address, one address per cycle, over addresses 0..DEPTH-1 with all lanes enabled. After writing DEPTH-1 it moves to READY.
  - READY: rdy=1. If clr=1 it moves to DRAIN.
  - DRAIN: a single cycle, rdy=0. It lets an input-stage write accepted on the previous edge land in the array. It then moves to INIT with the init address set to 0.
- rdy rises on the edge that enters READY, exactly DEPTH cycles after INIT starts.
- Reads in flight when clr is sampled complete normally with pre-clear data, and rd_valid still fires. No new reads issue until rdy returns.
- clr during DRAIN or INIT is ignored. An init in progress is not restarted.
- A request in the same cycle as clr is dropped with no side effect.
- rst_n asserted mid-init or mid-operation: all pipeline contents are discarded, and init restarts from address 0 after release.
- The init address counter is AW+1 bits wide so that the terminal-count compare does not wrap at DEPTH-1.

Decomposition:
- Package sp_ram_pkg holds:
  - the state enum {INIT, READY, DRAIN} (2-bit);
  - the function rd_latency(out_regs) returning 2+out_regs;
  - a localparam check that DW % BYTE_W == 0 and OUT_REGS <= 4, enforced by an elaboration-time assertion.
- Sub-module sp_ram_init_fsm contains the FSM, the init address counter and the rdy output. It provides the init write port (init_we, init_addr). The top muxes that port over the user write port; init has priority, and the two never overlap thanks to the DRAIN state.
- Array, byte-lane write loop and output pipeline stay in the top module.

Test Plan:
- Reset, then wait: rdy=0 for exactly DEPTH cycles (1024 with defaults) after rst_n rises, then 1. Read addresses 0, 512 and 1023 -> dout=0 each, with rd_valid 3 cycles after the request.
- Byte enables: write addr 5 din=64'h1111_2222_3333_4444 be=8'hFF. Then write din=64'hAAAA_AAAA_AAAA_AAAA be=8'h0F. Read addr 5 -> 64'h1111_2222_AAAA_AAAA.
- Back-to-back: 16 consecutive reads of addresses 0..15, each pre-written with value = address. Required: 16 consecutive rd_valid cycles with dout = 0..15 in order. Repeat with OUT_REGS=0 (latency 2) and OUT_REGS=3 (latency 5).
- Write then immediate read of the same address on the next cycle: write addr 7 = 64'hDEAD_BEEF, read addr 7 -> 64'hDEAD_BEEF.
- Clear: issue a read of addr 3 (=0x33), then clr on the following cycle with a simultaneous req.
  - The read completes with 0x33.
  - The simultaneous req is dropped.
  - rdy falls for 1+DEPTH cycles.
  - Afterwards, addr 3 reads 0.
- Reset mid-init: assert rst_n low 100 cycles into init -> rd_valid=0 and dout=0 immediately. After release, rdy returns a full DEPTH cycles later.
